e_s_out_ports: RTL
==================

Name: e_s_out_ports

Overview:
- Receiving end of the CPU's output-port write path.
- Captures each write the control unit issues via rwe1..rwe4 and buffers it in a small per-port FIFO.
- Delivers each buffered word to an external device over a 4-phase valid/ack handshake.
- Sits between the datapath's sec-selected output data (register or memory) and the four physical output ports, replacing the plain port registers.

Parameters:
- WIDTH, 8: data width of each port.
- DEPTH, 2: FIFO entries per port; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rwe1  in  1  write strobe, port 0.
- rwe2  in  1  write strobe, port 1.
- rwe3  in  1  write strobe, port 2.
- rwe4  in  1  write strobe, port 3.
- din  in  WIDTH  write data, shared by all ports.
- out_data  out  4*WIDTH  port i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  4  per-port request line.
- out_ack  in  4  per-port acknowledge from the device; same clock domain, no synchronizer.
- full  out  4  port i FIFO holds DEPTH words.
- overflow  out  4  sticky: a write to port i was dropped.

Behaviour:
- Reset (reset=0), asynchronous:
  - out_data=0, out_valid=0, full=0, overflow=0.
  - All FIFOs emptied; all channel FSMs go to IDLE.
  - Takes effect immediately, including mid-handshake.
- Push rules:
  - rwe(i+1)=1 at a rising edge pushes din into port i's FIFO.
  - Strobes are evaluated independently. Several asserted together push the same din into each enabled port.
- Push to a full port:
  - The word is dropped, FIFO contents are unchanged, and overflow[i] is set.
  - overflow[i] clears only on reset.
  - Exception: a push while full in the same cycle as a pop (REQ with ack=1) is accepted; the count is unchanged.
- FIFO: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap, plus a count of log2(DEPTH)+1 bits. full = (count==DEPTH).
- Channel FSM, per port:
  - IDLE: if count>0, load the head word into out_data[i], set out_valid[i]=1, and go to REQ. Otherwise stay in IDLE.
  - REQ:
    - out_valid[i] and out_data[i] are held stable.
    - When out_ack[i]=1: pop the head, clear out_valid[i], and go to REL.
  - REL: when out_ack[i]=0, go to IDLE. This blocks a new request until ack is released.
  - out_ack[i]=1 in IDLE is ignored.
- Data retention: out_data[i] keeps the last delivered word in IDLE and REL.
- Latency:
  - A push at edge n to an empty port in IDLE gives out_valid=1 with the data after edge n+1.
  - Minimum cycle per word is 3 edges: IDLE, REQ, REL, with ack asserted and released promptly.
- Port independence: ports never interact, and no CPU stall is generated. Software polls full or overflow through the input path if needed.

Decomposition:
- Package e_s_pkg:
  - N_PORTS=4.
  - FSM state encoding IDLE=2'd0, REQ=2'd1, REL=2'd2.
  - Default WIDTH and DEPTH constants.
- Sub-module e_s_out_chan: one FIFO plus FSM plus the overflow flag for a single port.
  - Ports: clock, reset, we, din, data, valid, ack, full, overflow.
  - Instantiated 4 times by a generate loop in e_s_out_ports.

Test Plan:
1. Reset: hold reset=0 with random rwe, din and ack -> all outputs 0. Release, idle 5 cycles -> outputs stay 0.
2. Single transfer:
   - rwe1=1, din=8'h5A for one edge -> after the next edge, out_valid[0]=1 and out_data[7:0]=8'h5A.
   - ack[0]=1 -> valid[0]=0 next edge.
   - Hold ack 2 cycles -> no new valid. Drop ack -> FSM returns to IDLE.
3. Overflow on port 2 (rwe3), ack held 0:
   - Writes 8'h01, 8'h02, 8'h03 on consecutive edges -> full[2]=1, overflow[2]=1, out_data[23:16]=8'h01.
   - Run handshakes -> 8'h01 then 8'h02 delivered, never 8'h03. overflow[2] stays 1.
4. Full, push and pop in the same cycle:
   - Port 0 full with 8'hA0, 8'hA1, in REQ.
   - ack[0]=1 together with rwe1, din=8'hA2 -> push accepted, overflow[0]=0.
   - Subsequent deliveries are 8'hA1 then 8'hA2.
5. Independence:
   - rwe2=1 and rwe4=1 together with din=8'h3C -> valid[1] and valid[3] set next edge, both carrying 8'h3C.
   - Ack port 3 only -> port 1 stays in REQ, data unchanged.
6. Reset mid-handshake:
   - Port 1 in REQ with one more word queued; pull reset=0 between edges -> out_valid[1] drops without a clock edge.
   - After release, no valid until a new write.

Source files
------------

// File: rtl/e_s_pkg.sv
// Shared constants and types for the output-port write path.
// Holds the port count, the channel FSM encoding and the default sizing.
package e_s_pkg;

    localparam int N_PORTS       = 4;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/e_s_out_chan.sv
// One output-port channel: a small FIFO, a 4-phase valid/ack handshake FSM
// and a sticky overflow flag.
module e_s_out_chan
    import e_s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ack,
    output logic             full,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             isFull;
    logic             push;
    logic             pop;

    // The head word stays in the FIFO while offered; it is popped on ack, which
    // is what lets a push into a full FIFO succeed in that same cycle.
    always_comb begin
        isFull     = (count_q == CW'(DEPTH));
        pop        = (state_q == REQ) && ack;
        push       = we && (!isFull || pop);
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q | (we & ~push);
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    data_d  = mem_q[rdPtr_q];
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign full     = isFull;
    assign overflow = overflow_q;

endmodule

// File: rtl/e_s_out_ports.sv
// Four buffered output ports fed by the CPU's rwe1..rwe4 write strobes,
// each delivering words to its device over an independent valid/ack handshake.
module e_s_out_ports
    import e_s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rwe1,
    input  logic                       rwe2,
    input  logic                       rwe3,
    input  logic                       rwe4,
    input  logic [WIDTH-1:0]           din,
    output logic [N_PORTS*WIDTH-1:0]   out_data,
    output logic [N_PORTS-1:0]         out_valid,
    input  logic [N_PORTS-1:0]         out_ack,
    output logic [N_PORTS-1:0]         full,
    output logic [N_PORTS-1:0]         overflow
);

    logic [N_PORTS-1:0] rwe;

    assign rwe = {rwe4, rwe3, rwe2, rwe1};

    for (genvar i = 0; i < N_PORTS; i++) begin : gen_chan
        e_s_out_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .we       (rwe[i]),
            .din      (din),
            .data     (out_data[i*WIDTH +: WIDTH]),
            .valid    (out_valid[i]),
            .ack      (out_ack[i]),
            .full     (full[i]),
            .overflow (overflow[i])
        );
    end

endmodule
